// File: rtl/grf_write_arbiter.sv
// Shares the register file's single write port between the writeback stage (fixed priority)
// and a small FIFO of mult/div results; also keeps a busy map that stalls decode on pending results.
module grf_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_a3,
  input  logic [31:0] pipe_data,
  input  logic [31:0] pipe_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_a3,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_a3,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  input  logic [4:0]  rd_a3,
  output logic        busy_stall,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_data,
  output logic [31:0] grf_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Result storage is never reset; only pointers, count and the busy map are control state.
  logic [4:0]    r_fifo_a3   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_busy;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head_a3;
  logic [31:0]   w_head_data;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_busy_nxt;

  function automatic logic reg_pending(input logic [31:0] map, input logic [4:0] addr);
    return (addr != 5'd0) && map[addr];
  endfunction

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign md_ready    = ~w_full;
  assign w_push      = md_valid & ~w_full;
  // Writeback always wins the port; the queue drains only on cycles writeback leaves free.
  assign w_pop       = ~pipe_we & ~w_empty;
  assign w_head_a3   = r_fifo_a3[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];
  assign w_head_pc   = r_fifo_pc[r_rptr];

  always_comb begin
    grf_we   = 1'b0;
    grf_a3   = 5'd0;
    grf_data = 32'd0;
    grf_pc   = 32'd0;
    if (pipe_we) begin
      grf_we   = 1'b1;
      grf_a3   = pipe_a3;
      grf_data = pipe_data;
      grf_pc   = pipe_pc;
    end else if (!w_empty) begin
      grf_we   = 1'b1;
      grf_a3   = w_head_a3;
      grf_data = w_head_data;
      grf_pc   = w_head_pc;
    end
  end

  // A new issue to the same register outranks the retiring older result.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) begin
      w_busy_nxt[w_head_a3] = 1'b0;
    end
    if (md_issue && (md_issue_a3 != 5'd0)) begin
      w_busy_nxt[md_issue_a3] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  assign busy_stall = reg_pending(r_busy, rd_a1) |
                      reg_pending(r_busy, rd_a2) |
                      reg_pending(r_busy, rd_a3);

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_fifo_a3[r_wptr]   <= md_a3;
      r_fifo_data[r_wptr] <= md_data;
      r_fifo_pc[r_wptr]   <= md_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter (DEPTH=2): grant priority, FIFO order/wrap, scoreboard, reset.
module tb_grf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_data;
  logic [31:0] pipe_pc;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_a3;
  logic [31:0] md_data;
  logic [31:0] md_pc;
  logic        md_issue;
  logic [4:0]  md_issue_a3;
  logic [4:0]  rd_a1, rd_a2, rd_a3;
  logic        busy_stall;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_data;
  logic [31:0] grf_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  grf_write_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_a3(md_a3), .md_data(md_data), .md_pc(md_pc),
    .md_issue(md_issue), .md_issue_a3(md_issue_a3),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_a3(rd_a3),
    .busy_stall(busy_stall),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_data(grf_data), .grf_pc(grf_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; pipe_we = 1'b0; pipe_a3 = '0; pipe_data = '0; pipe_pc = '0;
    md_valid = 1'b0; md_a3 = '0; md_data = '0; md_pc = '0;
    md_issue = 1'b0; md_issue_a3 = '0; rd_a1 = '0; rd_a2 = '0; rd_a3 = '0;
  endtask

  task automatic pipe(input logic [4:0] a3, input logic [31:0] d);
    pipe_we = 1'b1; pipe_a3 = a3; pipe_data = d; pipe_pc = d + 32'h4;
  endtask

  task automatic md(input logic [4:0] a3, input logic [31:0] d, input logic [31:0] pc);
    md_valid = 1'b1; md_a3 = a3; md_data = d; md_pc = pc;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    idle();
    settle();
    check_eq("rst_ready", 32'(md_ready), 32'd1);
    check_eq("rst_stall", 32'(busy_stall), 32'd0);
    check_eq("rst_we", 32'(grf_we), 32'd0);
    @(posedge clk); #1;
    pipe(5'd4, 32'hAA);
    settle();
    check_eq("rst_pipe_we", 32'(grf_we), 32'd1);
    check_eq("rst_pipe_a3", 32'(grf_a3), 32'd4);

    // Single accepted result reaches the idle port one cycle later
    tick(); idle();
    md(5'd8, 32'h12345678, 32'h3000);
    settle();
    check_eq("t1_ready", 32'(md_ready), 32'd1);
    check_eq("t1_no_bypass", 32'(grf_we), 32'd0);
    tick(); idle();
    settle();
    check_eq("t1_we", 32'(grf_we), 32'd1);
    check_eq("t1_a3", 32'(grf_a3), 32'd8);
    check_eq("t1_data", grf_data, 32'h12345678);
    check_eq("t1_pc", grf_pc, 32'h3000);
    tick();
    settle();
    check_eq("t1_empty_we", 32'(grf_we), 32'd0);
    check_eq("t1_empty_a3", 32'(grf_a3), 32'd0);

    // Writeback holds the port for 4 cycles while two results queue
    tick(); idle();
    pipe(5'd2, 32'h22);
    md(5'd9, 32'h99, 32'h900);
    settle();
    check_eq("t2_c0_a3", 32'(grf_a3), 32'd2);
    check_eq("t2_c0_ready", 32'(md_ready), 32'd1);
    tick();
    md(5'd10, 32'hA0, 32'hA00);
    settle();
    check_eq("t2_c1_a3", 32'(grf_a3), 32'd2);
    check_eq("t2_c1_ready", 32'(md_ready), 32'd1);
    tick();
    md(5'd11, 32'hBB, 32'hB00);
    settle();
    check_eq("t2_c2_a3", 32'(grf_a3), 32'd2);
    check_eq("t2_c2_ready", 32'(md_ready), 32'd0);
    tick();
    settle();
    check_eq("t2_c3_a3", 32'(grf_a3), 32'd2);
    check_eq("t2_c3_data", grf_data, 32'h22);
    check_eq("t2_c3_ready", 32'(md_ready), 32'd0);
    tick(); idle();
    settle();
    check_eq("t2_pop9_a3", 32'(grf_a3), 32'd9);
    check_eq("t2_pop9_data", grf_data, 32'h99);
    check_eq("t2_pop9_pc", grf_pc, 32'h900);
    tick();
    settle();
    check_eq("t2_pop10_a3", 32'(grf_a3), 32'd10);
    check_eq("t2_pop10_data", grf_data, 32'hA0);
    check_eq("t2_pop10_ready", 32'(md_ready), 32'd1);
    tick();
    settle();
    check_eq("t2_drained_we", 32'(grf_we), 32'd0);

    // Scoreboard: issue sets busy, pop releases it one cycle later
    tick(); idle();
    md_issue = 1'b1; md_issue_a3 = 5'd5;
    settle();
    check_eq("t3_issue_same_cycle", 32'(busy_stall), 32'd0);
    tick(); idle();
    rd_a1 = 5'd5;
    settle();
    check_eq("t3_stall_a1", 32'(busy_stall), 32'd1);
    tick(); idle();
    md_issue = 1'b1; md_issue_a3 = 5'd0;
    settle();
    check_eq("t3_rd0_stall", 32'(busy_stall), 32'd0);
    tick(); idle();
    rd_a3 = 5'd5;
    settle();
    check_eq("t3_stall_a3", 32'(busy_stall), 32'd1);
    tick(); idle();
    rd_a2 = 5'd5;
    md(5'd5, 32'h55, 32'h500);
    settle();
    check_eq("t3_stall_a2", 32'(busy_stall), 32'd1);
    tick(); idle();
    rd_a2 = 5'd5;
    settle();
    check_eq("t3_pop5_a3", 32'(grf_a3), 32'd5);
    check_eq("t3_stall_during_pop", 32'(busy_stall), 32'd1);
    tick();
    settle();
    check_eq("t3_released", 32'(busy_stall), 32'd0);

    // Full FIFO with a free port: pop but no push, then steady push+pop across wraps
    tick(); idle();
    pipe(5'd1, 32'h11);
    md(5'd12, 32'hC0, 32'hC00);
    tick();
    md(5'd13, 32'hD0, 32'hD00);
    tick();
    pipe_we = 1'b0;
    md(5'd14, 32'h0E, 32'hE00);
    settle();
    check_eq("t4_full_ready", 32'(md_ready), 32'd0);
    check_eq("t4_full_a3", 32'(grf_a3), 32'd12);
    tick();
    settle();
    check_eq("t4_after_ready", 32'(md_ready), 32'd1);
    check_eq("t4_after_a3", 32'(grf_a3), 32'd13);
    tick();
    settle();
    check_eq("t4_head14_a3", 32'(grf_a3), 32'd14);
    check_eq("t4_head14_data", grf_data, 32'h0E);
    for (int i = 0; i < 5; i++) begin
      tick();
      md(5'(15 + i), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      settle();
      check_eq($sformatf("t4_wrap%0d_ready", i), 32'(md_ready), 32'd1);
    end
    tick(); idle();
    settle();
    check_eq("t4_wrap_last_a3", 32'(grf_a3), 32'd19);
    check_eq("t4_wrap_last_data", grf_data, 32'h1004);
    check_eq("t4_wrap_last_pc", grf_pc, 32'h2004);
    tick();
    settle();
    check_eq("t4_wrap_drained", 32'(grf_we), 32'd0);

    // Issue to $7 on the same edge an older $7 result pops: set wins
    tick(); idle();
    md(5'd7, 32'h77, 32'h700);
    tick(); idle();
    md_issue = 1'b1; md_issue_a3 = 5'd7;
    settle();
    check_eq("t5_pop7_a3", 32'(grf_a3), 32'd7);
    tick(); idle();
    rd_a1 = 5'd7;
    settle();
    check_eq("t5_busy7_kept", 32'(busy_stall), 32'd1);

    // Reset with two queued entries and busy[3] set
    tick(); idle();
    pipe(5'd1, 32'h11);
    md(5'd20, 32'h200, 32'h2000);
    md_issue = 1'b1; md_issue_a3 = 5'd3;
    tick();
    md(5'd21, 32'h210, 32'h2100);
    md_issue = 1'b0;
    tick();
    md_valid = 1'b0;
    rd_a1 = 5'd3;
    settle();
    check_eq("t6_pre_ready", 32'(md_ready), 32'd0);
    check_eq("t6_pre_stall", 32'(busy_stall), 32'd1);
    tick(); idle();
    reset = 1'b1;
    md(5'd22, 32'h220, 32'h2200);
    md_issue = 1'b1; md_issue_a3 = 5'd4;
    tick(); idle();
    rd_a1 = 5'd3; rd_a2 = 5'd4; rd_a3 = 5'd7;
    settle();
    check_eq("t6_post_we", 32'(grf_we), 32'd0);
    check_eq("t6_post_ready", 32'(md_ready), 32'd1);
    check_eq("t6_post_stall", 32'(busy_stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
